// File: rtl/rgb_fade_pkg.sv
// Shared types and width helpers for the per-channel RGB fader.
package rgb_fade_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } fade_state_e;

  // Unity gain for a given gain resolution
  function automatic int unsigned gmax(input int unsigned gain_w);
    return 32'd1 << gain_w;
  endfunction

  // Product width: pixel times a gain that can reach 2**gain_w
  function automatic int unsigned prod_w(input int unsigned data_w, input int unsigned gain_w);
    return data_w + gain_w + 1;
  endfunction

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_GAIN_W = 4;
  localparam int unsigned DEF_PROD_W = DEF_DATA_W + DEF_GAIN_W + 1;

endpackage

// File: rtl/rgb_fade_channel.sv
// One colour channel: switch synchroniser, gain FSM and 2-stage scaler.
module rgb_fade_channel
  import rgb_fade_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned GAIN_W  = DEF_GAIN_W,
  parameter int unsigned FADE_EN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sw_raw,
  input  logic              step,
  input  logic [DATA_W-1:0] in_data,
  input  logic              valid_s1,
  output logic [DATA_W-1:0] out_data,
  output logic              busy_next
);

  localparam int unsigned PROD_W = prod_w(DATA_W, GAIN_W);
  localparam logic [GAIN_W:0] G_MAX  = (GAIN_W+1)'(gmax(GAIN_W));
  localparam logic [GAIN_W:0] G_ONE  = (GAIN_W+1)'(1);
  localparam logic [GAIN_W:0] G_ZERO = '0;

  logic              sync_q1;
  logic              sw_s;
  fade_state_e       state, state_nxt;
  logic [GAIN_W:0]   gain, gain_nxt;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] shifted;
  logic              unused_prod_lo;

  // Two-flop synchroniser for the raw switch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sw_s    <= 1'b0;
    end else begin
      sync_q1 <= sw_raw;
      sw_s    <= sync_q1;
    end
  end

  // Gain/state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= OFF;
      gain  <= '0;
    end else begin
      state <= state_nxt;
      gain  <= gain_nxt;
    end
  end

  // Next gain/state, evaluated only on step cycles
  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    if (step) begin
      if (FADE_EN == 0) begin
        gain_nxt  = sw_s ? G_MAX : G_ZERO;
        state_nxt = sw_s ? ON : OFF;
      end else begin
        unique case (state)
          OFF: if (sw_s) begin
            gain_nxt  = G_ONE;
            state_nxt = (G_ONE == G_MAX) ? ON : RAMP_UP;
          end
          ON: if (!sw_s) begin
            gain_nxt  = G_MAX - G_ONE;
            state_nxt = (gain_nxt == G_ZERO) ? OFF : RAMP_DOWN;
          end
          RAMP_UP, RAMP_DOWN: begin
            if (sw_s) begin
              gain_nxt  = (gain < G_MAX) ? gain + G_ONE : G_MAX;
              state_nxt = (gain_nxt == G_MAX) ? ON : RAMP_UP;
            end else begin
              gain_nxt  = (gain > G_ZERO) ? gain - G_ONE : G_ZERO;
              state_nxt = (gain_nxt == G_ZERO) ? OFF : RAMP_DOWN;
            end
          end
          default: begin
            state_nxt = OFF;
            gain_nxt  = '0;
          end
        endcase
      end
    end
  end

  assign busy_next = (state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN);

  // Stage 1: scale by the post-update gain so a step applies to the same-cycle pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prod <= '0;
    else          prod <= PROD_W'(in_data) * PROD_W'(gain_nxt);
  end

  assign shifted        = prod >> GAIN_W;
  assign unused_prod_lo = ^prod[GAIN_W-1:0];

  // Stage 2: drop the fraction and force blanking to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       out_data <= '0;
    else if (!valid_s1)                 out_data <= '0;
    else if (|shifted[PROD_W-1:DATA_W]) out_data <= '1;
    else                                out_data <= shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/rgb_channel_fader.sv
// Frame-synchronous per-channel fader between pixel generator and VGA pins.
module rgb_channel_fader
  import rgb_fade_pkg::*;
#(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned GAIN_W      = DEF_GAIN_W,
  parameter int unsigned STEP_FRAMES = 1,
  parameter int unsigned FADE_EN     = 1,
  parameter bit          SYNC_RST    = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        sw_en,
  input  logic                     frame_start,
  input  logic                     in_valid,
  input  logic                     in_hsync,
  input  logic                     in_vsync,
  input  logic [NUM_CH*DATA_W-1:0] in_pixel,
  output logic                     out_valid,
  output logic                     out_hsync,
  output logic                     out_vsync,
  output logic [NUM_CH*DATA_W-1:0] out_pixel,
  output logic                     fade_busy
);

  localparam int unsigned CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_FRAMES - 1);

  logic [CNT_W-1:0]  frame_cnt;
  logic              step;
  logic              valid_s1, hsync_s1, vsync_s1;
  logic [NUM_CH-1:0] busy_next;

  assign step = frame_start && (frame_cnt == CNT_LAST);

  // Frame counter dividing frame_start down to gain steps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         frame_cnt <= '0;
    else if (step)        frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 1'b1;
  end

  // Valid/sync delay line matching the 2-stage scaler
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_s1  <= 1'b0;
      hsync_s1  <= SYNC_RST;
      vsync_s1  <= SYNC_RST;
      out_valid <= 1'b0;
      out_hsync <= SYNC_RST;
      out_vsync <= SYNC_RST;
    end else begin
      valid_s1  <= in_valid;
      hsync_s1  <= in_hsync;
      vsync_s1  <= in_vsync;
      out_valid <= valid_s1;
      out_hsync <= hsync_s1;
      out_vsync <= vsync_s1;
    end
  end

  // Busy flag registered from the post-update channel states
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fade_busy <= 1'b0;
    else          fade_busy <= |busy_next;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rgb_fade_channel #(
      .DATA_W  (DATA_W),
      .GAIN_W  (GAIN_W),
      .FADE_EN (FADE_EN)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw_raw    (sw_en[c]),
      .step      (step),
      .in_data   (in_pixel[c*DATA_W +: DATA_W]),
      .valid_s1  (valid_s1),
      .out_data  (out_pixel[c*DATA_W +: DATA_W]),
      .busy_next (busy_next[c])
    );
  end

endmodule

// File: tb/tb_rgb_channel_fader.sv
module tb_rgb_channel_fader;

  logic        clk;
  logic        reset_n;
  logic [2:0]  sw_en;
  logic        frame_start;
  logic        in_valid, in_hsync, in_vsync;
  logic [11:0] in_pixel;

  logic        a_valid, a_hsync, a_vsync, a_busy;
  logic [11:0] a_pixel;
  logic        b_valid, b_hsync, b_vsync, b_busy;
  logic [11:0] b_pixel;
  logic        c_valid, c_hsync, c_vsync, c_busy;
  logic [11:0] c_pixel;

  int checks = 0;
  int errors = 0;

  rgb_channel_fader dut_a (
    .clk(clk), .reset_n(reset_n), .sw_en(sw_en), .frame_start(frame_start),
    .in_valid(in_valid), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_pixel(in_pixel),
    .out_valid(a_valid), .out_hsync(a_hsync), .out_vsync(a_vsync),
    .out_pixel(a_pixel), .fade_busy(a_busy)
  );

  rgb_channel_fader #(.STEP_FRAMES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .sw_en(sw_en), .frame_start(frame_start),
    .in_valid(in_valid), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_pixel(in_pixel),
    .out_valid(b_valid), .out_hsync(b_hsync), .out_vsync(b_vsync),
    .out_pixel(b_pixel), .fade_busy(b_busy)
  );

  rgb_channel_fader #(.FADE_EN(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .sw_en(sw_en), .frame_start(frame_start),
    .in_valid(in_valid), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_pixel(in_pixel),
    .out_valid(c_valid), .out_hsync(c_hsync), .out_vsync(c_vsync),
    .out_pixel(c_pixel), .fade_busy(c_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    sw_en = 3'b111; in_pixel = 12'hFFF; in_valid = 1'b1; in_hsync = 1'b0; in_vsync = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (a_pixel !== 12'h000) begin errors++; $display("FAIL reset_pixel: got %h expected %h", a_pixel, 12'h000); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_valid); end
    checks++; if ({a_hsync, a_vsync} !== 2'b11) begin errors++; $display("FAIL reset_syncs: got %b expected 11", {a_hsync, a_vsync}); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    reset_n = 1'b1;
    repeat (3) tick();
    repeat (4) frame();
    checks++; if (a_pixel !== 12'h333) begin errors++; $display("FAIL pre_reset_ramp: got %h expected %h", a_pixel, 12'h333); end
    // asynchronous reset mid-ramp
    reset_n = 1'b0;
    #1;
    checks++; if ({a_pixel, a_valid, a_busy} !== 14'h0) begin errors++; $display("FAIL midramp_reset: got %h/%b/%b expected 000/0/0", a_pixel, a_valid, a_busy); end
    checks++; if ({a_hsync, a_vsync} !== 2'b11) begin errors++; $display("FAIL midramp_syncs: got %b expected 11", {a_hsync, a_vsync}); end
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    checks++; if (a_pixel !== 12'h000 || a_valid !== 1'b1) begin errors++; $display("FAIL gain_zero_after_reset: got %h/%b expected 000/1", a_pixel, a_valid); end
    frame();
    checks++; if (a_busy !== 1'b1 || a_pixel !== 12'h000) begin errors++; $display("FAIL restart_from_off: got busy %b pix %h expected 1/000", a_busy, a_pixel); end
  endtask

  task automatic test_fade_up();
    sw_en = 3'b111; in_pixel = 12'hFFF; in_valid = 1'b1;
    do_reset();
    frame();
    checks++; if (a_pixel !== 12'h000) begin errors++; $display("FAIL fade_step1_pix: got %h expected %h", a_pixel, 12'h000); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL fade_step1_busy: got %b expected 1", a_busy); end
    checks++; if (c_pixel !== 12'hFFF || c_busy !== 1'b0) begin errors++; $display("FAIL nofade_jump_up: got %h/%b expected FFF/0", c_pixel, c_busy); end
    repeat (7) frame();
    checks++; if (a_pixel !== 12'h777) begin errors++; $display("FAIL fade_step8_pix: got %h expected %h", a_pixel, 12'h777); end
    checks++; if (b_pixel !== 12'h333) begin errors++; $display("FAIL sf2_step8_pix: got %h expected %h", b_pixel, 12'h333); end
    repeat (7) frame();
    checks++; if (a_pixel !== 12'hEEE || a_busy !== 1'b1) begin errors++; $display("FAIL fade_step15: got %h/%b expected EEE/1", a_pixel, a_busy); end
    frame();
    checks++; if (a_pixel !== 12'hFFF) begin errors++; $display("FAIL fade_step16_pix: got %h expected %h", a_pixel, 12'hFFF); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL fade_step16_busy: got %b expected 0", a_busy); end
    checks++; if (b_pixel !== 12'h777) begin errors++; $display("FAIL sf2_step16_pix: got %h expected %h", b_pixel, 12'h777); end
    repeat (2) frame();
    checks++; if (a_pixel !== 12'hFFF || a_busy !== 1'b0) begin errors++; $display("FAIL on_holds: got %h/%b expected FFF/0", a_pixel, a_busy); end
  endtask

  task automatic test_latency();
    in_pixel = 12'hFFF; in_valid = 1'b1; in_hsync = 1'b0; in_vsync = 1'b0;
    tick();
    in_pixel = 12'hA5C; in_hsync = 1'b1; in_vsync = 1'b1;
    tick();
    in_pixel = 12'hFFF; in_hsync = 1'b0;
    checks++; if (a_pixel !== 12'hFFF || a_hsync !== 1'b0) begin errors++; $display("FAIL lat_n1: got %h/%b expected FFF/0", a_pixel, a_hsync); end
    tick();
    in_vsync = 1'b0;
    checks++; if (a_pixel !== 12'hA5C || a_hsync !== 1'b1 || a_vsync !== 1'b1) begin errors++; $display("FAIL lat_n2: got %h/%b/%b expected A5C/1/1", a_pixel, a_hsync, a_vsync); end
    tick();
    checks++; if (a_pixel !== 12'hFFF || a_hsync !== 1'b0 || a_vsync !== 1'b1) begin errors++; $display("FAIL lat_n3: got %h/%b/%b expected FFF/0/1", a_pixel, a_hsync, a_vsync); end
    tick();
    checks++; if (a_vsync !== 1'b0) begin errors++; $display("FAIL lat_vs_width: got %b expected 0", a_vsync); end
  endtask

  task automatic test_blanking();
    in_valid = 1'b0; in_pixel = 12'hFFF; in_vsync = 1'b1; in_hsync = 1'b0;
    repeat (2) tick();
    checks++; if (a_pixel !== 12'h000 || a_valid !== 1'b0) begin errors++; $display("FAIL blank_pix: got %h/%b expected 000/0", a_pixel, a_valid); end
    checks++; if (a_vsync !== 1'b1 || a_hsync !== 1'b0) begin errors++; $display("FAIL blank_syncs: got %b%b expected 01", a_hsync, a_vsync); end
    in_valid = 1'b1; in_vsync = 1'b0;
    repeat (2) tick();
    checks++; if (a_pixel !== 12'hFFF || a_valid !== 1'b1) begin errors++; $display("FAIL unblank: got %h/%b expected FFF/1", a_pixel, a_valid); end
  endtask

  task automatic test_reversal();
    sw_en = 3'b111; in_pixel = 12'hFFF; in_valid = 1'b1;
    do_reset();
    repeat (5) frame();
    checks++; if (a_pixel !== 12'h444) begin errors++; $display("FAIL rev_gain5: got %h expected %h", a_pixel, 12'h444); end
    sw_en = 3'b110;
    repeat (3) tick();
    frame();
    checks++; if (a_pixel !== 12'h553 || a_busy !== 1'b1) begin errors++; $display("FAIL rev_first_down: got %h/%b expected 553/1", a_pixel, a_busy); end
    checks++; if (c_pixel !== 12'hFF0) begin errors++; $display("FAIL nofade_ch0_off: got %h expected %h", c_pixel, 12'hFF0); end
    repeat (3) frame();
    checks++; if (a_pixel !== 12'h880) begin errors++; $display("FAIL rev_gain1: got %h expected %h", a_pixel, 12'h880); end
    frame();
    checks++; if (a_pixel !== 12'h990) begin errors++; $display("FAIL rev_gain0: got %h expected %h", a_pixel, 12'h990); end
  endtask

  task automatic test_param_sweeps();
    sw_en = 3'b111; in_pixel = 12'hFFF; in_valid = 1'b1;
    do_reset();
    frame();
    checks++; if (b_busy !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL sf2_first_pulse: got b %b a %b expected 0/1", b_busy, a_busy); end
    frame();
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL sf2_second_pulse: got %b expected 1", b_busy); end
    sw_en = 3'b000;
    do_reset();
    frame();
    checks++; if (c_pixel !== 12'h000 || c_busy !== 1'b0) begin errors++; $display("FAIL nofade_off: got %h/%b expected 000/0", c_pixel, c_busy); end
    sw_en = 3'b100;
    repeat (3) tick();
    checks++; if (c_pixel !== 12'h000) begin errors++; $display("FAIL nofade_before_step: got %h expected %h", c_pixel, 12'h000); end
    frame();
    checks++; if (c_pixel !== 12'hF00 || c_busy !== 1'b0) begin errors++; $display("FAIL nofade_b_on: got %h/%b expected F00/0", c_pixel, c_busy); end
    sw_en = 3'b000;
    repeat (3) tick();
    frame();
    checks++; if (c_pixel !== 12'h000 || c_busy !== 1'b0) begin errors++; $display("FAIL nofade_b_off: got %h/%b expected 000/0", c_pixel, c_busy); end
  endtask

  initial begin
    reset_n = 1'b0; sw_en = '0; frame_start = 1'b0;
    in_valid = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_pixel = '0;
    test_reset();
    test_fade_up();
    test_latency();
    test_blanking();
    test_reversal();
    test_param_sweeps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_channel_fader.md
Name: rgb_channel_fader

Overview:
Parametrised per-channel colour gate for the VGA output path. Replaces the hard on/off channel switch with a frame-synchronous fade ramp per channel. Every channel has its own switch, synchroniser, gain FSM and multiplier. Sits between the pixel generator and the VGA pins, with pixel data and syncs pipelined together so timing is preserved and blanking is forced to zero.

Parameters:
NUM_CH, 3, number of colour channels (R,G,B = 0,1,2; channel 0 in LSBs of pixel bus)
DATA_W, 4, bits per channel
GAIN_W, 4, gain resolution; gain range 0..GMAX where GMAX = 2**GAIN_W (unity)
STEP_FRAMES, 1, frame_start pulses per gain step (>=1)
FADE_EN, 1, 1 = ramp; 0 = gain jumps 0<->GMAX on the next step edge
SYNC_RST, 1, reset/idle level of out_hsync/out_vsync

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
sw_en  in  NUM_CH  per-channel enable switches (asynchronous, raw)
frame_start  in  1  one-cycle pulse at start of each frame
in_valid  in  1  display-enable for in_pixel
in_hsync  in  1  horizontal sync
in_vsync  in  1  vertical sync
in_pixel  in  NUM_CH*DATA_W  packed channel data
out_valid  out  1  in_valid delayed 2
out_hsync  out  1  in_hsync delayed 2
out_vsync  out  1  in_vsync delayed 2
out_pixel  out  NUM_CH*DATA_W  scaled channel data
fade_busy  out  1  any channel ramping

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous and active-low. The only clock is clk.
- Reset values: out_pixel=0, out_valid=0, out_hsync=out_vsync=SYNC_RST, fade_busy=0, all gains 0, all FSMs OFF, frame counter 0, synchroniser flops 0.
- Reset is allowed mid-ramp. It returns the block to the reset state at once. The first step after release starts from OFF.
- sw_en passes through a 2-flop synchroniser per bit. Only the synchronised value (sw_s) is used.
- Step edge:
  - frame_cnt counts frame_start pulses from 0 to STEP_FRAMES-1.
  - step = frame_start && frame_cnt==STEP_FRAMES-1. On that cycle frame_cnt wraps to 0.
  - All gain and state updates happen only on step cycles.
- Per-channel FSM {OFF, RAMP_UP, ON, RAMP_DOWN}, applied on step when FADE_EN=1:
  - OFF: if sw_s, gain<=1 and go to RAMP_UP (if GMAX==1, go to ON). Otherwise stay.
  - RAMP_UP, sw_s=1: gain<=gain+1. If the new gain equals GMAX, go to ON.
  - RAMP_UP, sw_s=0: gain<=gain-1 and go to RAMP_DOWN. If the new gain is 0, go to OFF.
  - ON: if !sw_s, gain<=GMAX-1 and go to RAMP_DOWN. Otherwise stay.
  - RAMP_DOWN, sw_s=0: gain<=gain-1. If the new gain is 0, go to OFF.
  - RAMP_DOWN, sw_s=1: gain<=gain+1 and go to RAMP_UP. If the new gain is GMAX, go to ON.
  - Gain never wraps; it is held in 0..GMAX.
- FADE_EN=0: on step, gain<=sw_s ? GMAX : 0. State is ON or OFF only; fade_busy stays 0.
- fade_busy = OR over channels of (state==RAMP_UP || state==RAMP_DOWN). It is registered and reflects the state after the update.
- Datapath, 2-cycle latency:
  - Stage 1 registers prod_c = in_pixel_c * gain_c (DATA_W+GAIN_W+1 bits), plus valid and syncs.
  - Stage 2 registers out_c = prod_c >> GAIN_W. The result is exact at GMAX and never exceeds 2**DATA_W-1.
- Blanking: out_pixel=0 whenever the stage-2 valid is 0, regardless of data.
- Gain changes at a step take effect on the pixel sampled in the same cycle. Since frame_start falls in blanking, no visible tearing occurs.

Decomposition:
- Package rgb_fade_pkg holds:
  - typedef enum fade_state_e {OFF, RAMP_UP, ON, RAMP_DOWN}
  - function gmax(GAIN_W)
  - localparam widths for the product
- Sub-module rgb_fade_channel holds the synchroniser, FSM, gain register and the 2-stage multiply for one channel. The top level instantiates it NUM_CH times with a generate loop, and contains the frame counter, the shared sync/valid delay line and the fade_busy OR.

Test Plan:
1. Reset: assert reset_n=0 mid-stream -> next sample shows out_pixel=0, out_valid=0, syncs=1, fade_busy=0. Release -> all gains 0.
2. Fade up (defaults): sw_en=3'b111, in_pixel=12'hFFF, in_valid=1, one frame_start per frame:
   - After step 1: gain=1, each channel 0 ((15*1)>>4), fade_busy=1.
   - After step 8: each channel 7.
   - After step 16: out_pixel=12'hFFF, ON, fade_busy=0.
3. Latency/alignment at unity gain: in_pixel=12'hA5C with valid and hsync pulse at cycle N -> out_pixel=12'hA5C and the hsync pulse both at N+2. Pulse widths unchanged.
4. Blanking: in_valid=0, in_pixel=12'hFFF -> out_pixel=0 two cycles later. Syncs still propagate.
5. Reversal: ramp channel 0 to gain 5, then sw_en[0]=0 -> next step gain 4, RAMP_DOWN. After 4 more steps gain 0, OFF, channel 0 output 0. Channels 1/2 unaffected.
6. Parameter sweeps:
   - STEP_FRAMES=2: gain changes only on every 2nd frame_start.
   - FADE_EN=0: a toggle of sw_en[2] gives a B output jump 0 -> 15 on the first step after sync, with fade_busy=0 throughout.
